memory_port_sequencer: RTL

Single-port memory sequencer that shares one synchronous RAM between instruction fetch and data/stack accesses. It drives the control, select and commit strobes around the memory address handler, counts RAM read latency, and returns handshaked completions to the core. It sits between the core's fetch/execute logic and the RAM, and is the only block that commits PC and SP updates.

---
 rtl/memory_port_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_port_sequencer.sv
// Sequences one synchronous RAM between instruction fetch and data/stack accesses.
// Define STACK_FAULT_EN to reject push-at-limit and pop-when-empty through a one-cycle FAULT state.
module memory_port_sequencer #(
  parameter int unsigned ADDR_WIDTH           = 14,
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned READ_LATENCY         = 2,
  parameter int unsigned PRIVILEGED_STACK_TOP = 4096,
  parameter int unsigned USER_STACK_TOP       = 6144
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  output logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  input  logic                  data_req,
  input  logic [1:0]            data_op,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_done,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  stack_fault,
  input  logic [DATA_WIDTH-1:0] current_SP,
  input  logic                  privilege_mode_flag,
  output logic [2:0]            handler_control,
  output logic                  addr_select,
  output logic                  pc_write_enable,
  output logic                  sp_write_enable,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

`ifdef STACK_FAULT_EN
  localparam logic FAULT_EN = 1'b1;
`else
  localparam logic FAULT_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY - 1);

  // Stack limits live in RAM word-address space
  localparam logic [DATA_WIDTH-1:0] PRIV_MIN = DATA_WIDTH'(ADDR_WIDTH'(PRIVILEGED_STACK_TOP));
  localparam logic [DATA_WIDTH-1:0] USER_MIN = DATA_WIDTH'(ADDR_WIDTH'(USER_STACK_TOP));

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_PUSH  = 2'd2;
  localparam logic [1:0] OP_POP   = 2'd3;

  localparam logic [2:0] HC_PLAIN = 3'd0;
  localparam logic [2:0] HC_PUSH  = 3'd1;
  localparam logic [2:0] HC_POP   = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_DATA_READ  = 3'd2,
    S_DATA_WRITE = 3'd3,
    S_FAULT      = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_data_q, last_data_d;
  logic [2:0]            hc_q, hc_d;
  logic                  addr_sel_q, addr_sel_d;
  logic                  fetch_ready_q, fetch_ready_d;
  logic                  pc_we_q, pc_we_d;
  logic                  data_done_q, data_done_d;
  logic                  sp_we_q, sp_we_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  stack_fault_q, stack_fault_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] min_stack_c;
  logic                  stack_violation_c;
  logic                  rd_done_c;
  logic                  grant_data;

  assign min_stack_c       = privilege_mode_flag ? PRIV_MIN : USER_MIN;
  assign stack_violation_c = FAULT_EN &&
                             (((data_op == OP_PUSH) && (current_SP == min_stack_c)) ||
                              ((data_op == OP_POP)  && (current_SP == '1)));
  assign rd_done_c         = data_done_q && (state_q == S_DATA_READ);

  // Next-state and next-output logic; outputs are computed for the cycle after the edge
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_data_d   = last_data_q;
    hc_d          = hc_q;
    addr_sel_d    = addr_sel_q;
    data_done_d   = 1'b0;
    sp_we_d       = 1'b0;
    mem_we_d      = 1'b0;
    mem_wdata_d   = '0;
    stack_fault_d = 1'b0;
    // Data wins a tie unless the last completion was data, so neither side starves
    grant_data    = data_req && !(fetch_req && last_data_q);

    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          addr_sel_d = 1'b1;
          if (stack_violation_c) begin
            state_d       = S_FAULT;
            hc_d          = HC_PLAIN;
            data_done_d   = 1'b1;
            stack_fault_d = 1'b1;
          end else if ((data_op == OP_STORE) || (data_op == OP_PUSH)) begin
            state_d     = S_DATA_WRITE;
            hc_d        = (data_op == OP_PUSH) ? HC_PUSH : HC_PLAIN;
            mem_we_d    = 1'b1;
            mem_wdata_d = data_wdata;
            data_done_d = 1'b1;
            sp_we_d     = (data_op == OP_PUSH);
          end else begin
            state_d = S_DATA_READ;
            cnt_d   = LAST_CNT;
            hc_d    = (data_op == OP_POP) ? HC_POP : HC_PLAIN;
          end
        end else if (fetch_req) begin
          state_d    = S_FETCH;
          cnt_d      = LAST_CNT;
          addr_sel_d = 1'b0;
          hc_d       = HC_PLAIN;
        end
      end
      S_FETCH, S_DATA_READ: begin
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          hc_d        = HC_PLAIN;
          addr_sel_d  = 1'b0;
          last_data_d = (state_q == S_DATA_READ);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA_WRITE, S_FAULT: begin
        state_d     = S_IDLE;
        hc_d        = HC_PLAIN;
        addr_sel_d  = 1'b0;
        last_data_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read completions fire in the last latency cycle
    fetch_ready_d = (state_d == S_FETCH) && (cnt_d == '0);
    pc_we_d       = fetch_ready_d;
    if ((state_d == S_DATA_READ) && (cnt_d == '0)) begin
      data_done_d = 1'b1;
      sp_we_d     = (hc_d == HC_POP);
    end

    busy_d  = (state_d != S_IDLE);
    instr_d = fetch_ready_q ? mem_rdata : instr_q;
    rdata_d = rd_done_c ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      last_data_q   <= 1'b0;
      hc_q          <= HC_PLAIN;
      addr_sel_q    <= 1'b0;
      fetch_ready_q <= 1'b0;
      pc_we_q       <= 1'b0;
      data_done_q   <= 1'b0;
      sp_we_q       <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      stack_fault_q <= 1'b0;
      busy_q        <= 1'b0;
      instr_q       <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_data_q   <= last_data_d;
      hc_q          <= hc_d;
      addr_sel_q    <= addr_sel_d;
      fetch_ready_q <= fetch_ready_d;
      pc_we_q       <= pc_we_d;
      data_done_q   <= data_done_d;
      sp_we_q       <= sp_we_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      stack_fault_q <= stack_fault_d;
      busy_q        <= busy_d;
      instr_q       <= instr_d;
      rdata_q       <= rdata_d;
    end
  end

  // RAM data is only valid in the completion cycle, so it is passed through then and held afterwards
  assign instruction      = fetch_ready_q ? mem_rdata : instr_q;
  assign data_rdata       = rd_done_c ? mem_rdata : rdata_q;
  assign fetch_ready      = fetch_ready_q;
  assign pc_write_enable  = pc_we_q;
  assign data_done        = data_done_q;
  assign sp_write_enable  = sp_we_q;
  assign mem_write_enable = mem_we_q;
  assign mem_wdata        = mem_wdata_q;
  assign stack_fault      = stack_fault_q;
  assign handler_control  = hc_q;
  assign addr_select      = addr_sel_q;
  assign busy             = busy_q;

endmodule
